// File: rtl/dram_device.sv
// dram_device: single-bank SDRAM-style device model with an ACT/PRE/READ/WRITE
// command decoder, per-byte write enables and a CAS_LAT-deep read pipeline.
// Optional feature: define DRAM_TIMING_CHECK_EN to enforce tRCD / tRP.
module dram_device #(
  parameter int unsigned ROW_BITS = 11,
  parameter int unsigned COL_BITS = 10,
  parameter int unsigned CAS_LAT  = 4,
  parameter int unsigned TRCD     = 5,
  parameter int unsigned TRP      = 5
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        DRAM_CSn,
  input  logic [3:0]  DRAM_WEn,
  input  logic        DRAM_RASn,
  input  logic        DRAM_CASn,
  input  logic [10:0] DRAM_A,
  input  logic [31:0] DRAM_D,
  output logic [31:0] DRAM_Q,
  output logic        DRAM_valid,
  output logic        cmd_err
);

  localparam int unsigned AW    = ROW_BITS + COL_BITS;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ROW_BITS-1:0]   row_q, row_d;
  logic                  err_q, err_d;
  logic                  rd_fire, wr_fire;
  logic                  is_act, is_pre, is_rd, is_wr;
  logic                  trcd_ok, trp_ok;
  logic [AW-1:0]         addr;

  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           pipe_data_q [CAS_LAT];
  logic                  pipe_vld_q  [CAS_LAT];
  logic [31:0]           dq_q;
  logic                  dvalid_q;

  // Command decode; a deselected chip sees only NOPs.
  always_comb begin
    is_act = 1'b0;
    is_pre = 1'b0;
    is_rd  = 1'b0;
    is_wr  = 1'b0;
    if (!DRAM_CSn) begin
      is_act = !DRAM_RASn &&  DRAM_CASn && (DRAM_WEn == 4'hF);
      is_pre = !DRAM_RASn &&  DRAM_CASn && (DRAM_WEn == 4'h0);
      is_rd  =  DRAM_RASn && !DRAM_CASn && (DRAM_WEn == 4'hF);
      is_wr  =  DRAM_RASn && !DRAM_CASn && (DRAM_WEn != 4'hF);
    end
  end

  assign addr = {row_q, DRAM_A[COL_BITS-1:0]};

`ifdef DRAM_TIMING_CHECK_EN
  // Counters are loaded with the constraint at the accepted command and count
  // down once per edge; a value of 0 or 1 seen at an edge means the gap is met.
  localparam int unsigned TMAX = (TRCD > TRP) ? TRCD : TRP;
  localparam int unsigned TW   = $clog2(TMAX + 1) + 1;

  logic [TW-1:0] trcd_cnt_q, trp_cnt_q;

  assign trcd_ok = (trcd_cnt_q <= TW'(1));
  assign trp_ok  = (trp_cnt_q  <= TW'(1));

  // Timing counters for ACT->READ/WRITE and PRE->ACT spacing.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      trcd_cnt_q <= '0;
      trp_cnt_q  <= '0;
    end else begin
      if (state_q == IDLE && state_d == ACTIVE) trcd_cnt_q <= TW'(TRCD);
      else if (trcd_cnt_q != '0)                trcd_cnt_q <= trcd_cnt_q - TW'(1);
      if (state_q == ACTIVE && state_d == IDLE) trp_cnt_q  <= TW'(TRP);
      else if (trp_cnt_q != '0)                 trp_cnt_q  <= trp_cnt_q - TW'(1);
    end
  end
`else
  assign trcd_ok = 1'b1;
  assign trp_ok  = 1'b1;
`endif

  // Bank state machine: next state, row latch, command accept and error flag.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    err_d   = 1'b0;
    rd_fire = 1'b0;
    wr_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (is_act) begin
          if (trp_ok) begin
            state_d = ACTIVE;
            row_d   = DRAM_A[ROW_BITS-1:0];
          end else begin
            err_d = 1'b1;
          end
        end else if (is_pre || is_rd || is_wr) begin
          err_d = 1'b1;
        end
      end
      ACTIVE: begin
        if (is_act) begin
          err_d = 1'b1;
        end else if (is_pre) begin
          state_d = IDLE;
        end else if (is_rd) begin
          if (trcd_ok) rd_fire = 1'b1;
          else         err_d   = 1'b1;
        end else if (is_wr) begin
          if (trcd_ok) wr_fire = 1'b1;
          else         err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, open row and error pulse registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      row_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      err_q   <= err_d;
    end
  end

  // Storage array with per-byte write enables; contents survive reset.
  always_ff @(posedge ACLK) begin
    if (wr_fire) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (!DRAM_WEn[i]) mem_q[addr][8*i +: 8] <= DRAM_D[8*i +: 8];
      end
    end
  end

  // Read latency pipeline: stage 0 captures at the READ edge, the output
  // register loads CAS_LAT edges later, so in-flight reads are never cancelled.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int unsigned i = 0; i < CAS_LAT; i++) begin
        pipe_data_q[i] <= '0;
        pipe_vld_q[i]  <= 1'b0;
      end
      dq_q     <= '0;
      dvalid_q <= 1'b0;
    end else begin
      pipe_data_q[0] <= mem_q[addr];
      pipe_vld_q[0]  <= rd_fire;
      for (int unsigned i = 1; i < CAS_LAT; i++) begin
        pipe_data_q[i] <= pipe_data_q[i-1];
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
      end
      dvalid_q <= pipe_vld_q[CAS_LAT-1];
      if (pipe_vld_q[CAS_LAT-1]) dq_q <= pipe_data_q[CAS_LAT-1];
    end
  end

  assign DRAM_Q     = dq_q;
  assign DRAM_valid = dvalid_q;
  assign cmd_err    = err_q;

endmodule

// File: tb/tb_dram_device.sv
// Directed self-checking bench for dram_device (default parameters, CAS_LAT 4).
module tb_dram_device;

  localparam int unsigned CAS_LAT = 4;

  logic        ACLK;
  logic        ARESETn;
  logic        DRAM_CSn;
  logic [3:0]  DRAM_WEn;
  logic        DRAM_RASn;
  logic        DRAM_CASn;
  logic [10:0] DRAM_A;
  logic [31:0] DRAM_D;
  logic [31:0] DRAM_Q;
  logic        DRAM_valid;
  logic        cmd_err;

  int checks;
  int errors;

  dram_device #(
    .ROW_BITS(11),
    .COL_BITS(10),
    .CAS_LAT (CAS_LAT),
    .TRCD    (5),
    .TRP     (5)
  ) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .DRAM_CSn  (DRAM_CSn),
    .DRAM_WEn  (DRAM_WEn),
    .DRAM_RASn (DRAM_RASn),
    .DRAM_CASn (DRAM_CASn),
    .DRAM_A    (DRAM_A),
    .DRAM_D    (DRAM_D),
    .DRAM_Q    (DRAM_Q),
    .DRAM_valid(DRAM_valid),
    .cmd_err   (cmd_err)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_nop();
    DRAM_CSn  = 1'b1;
    DRAM_RASn = 1'b1;
    DRAM_CASn = 1'b1;
    DRAM_WEn  = 4'hF;
    DRAM_A    = '0;
    DRAM_D    = '0;
  endtask

  // Present one command for one rising edge, return 1 ns after that edge.
  task automatic drive(input logic csn, input logic rasn, input logic casn,
                       input logic [3:0] wen, input logic [10:0] a, input logic [31:0] d);
    DRAM_CSn  = csn;
    DRAM_RASn = rasn;
    DRAM_CASn = casn;
    DRAM_WEn  = wen;
    DRAM_A    = a;
    DRAM_D    = d;
    @(posedge ACLK);
    #1;
    set_nop();
  endtask

  task automatic nop();                     drive(1'b1, 1'b1, 1'b1, 4'hF, 11'h0, 32'h0); endtask
  task automatic act(input logic [10:0] r); drive(1'b0, 1'b0, 1'b1, 4'hF, r, 32'h0);     endtask
  task automatic pre();                     drive(1'b0, 1'b0, 1'b1, 4'h0, 11'h0, 32'h0); endtask
  task automatic rd(input logic [10:0] c);  drive(1'b0, 1'b1, 1'b0, 4'hF, c, 32'h0);     endtask
  task automatic wr(input logic [10:0] c, input logic [3:0] w, input logic [31:0] d);
    drive(1'b0, 1'b1, 1'b0, w, c, d);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) nop();
  endtask

  // READ, then expect exactly one valid cycle CAS_LAT edges later and a held Q.
  task automatic read_expect(input logic [10:0] c, input logic [31:0] exp, input string tag);
    logic early;
    early = 1'b0;
    rd(c);
    check({tag, "_err"}, 32'(cmd_err), 32'd0);
    if (DRAM_valid) early = 1'b1;
    for (int i = 1; i < int'(CAS_LAT); i++) begin
      nop();
      if (DRAM_valid) early = 1'b1;
    end
    check({tag, "_early"}, 32'(early), 32'd0);
    nop();
    check({tag, "_valid"}, 32'(DRAM_valid), 32'd1);
    check({tag, "_data"}, DRAM_Q, exp);
    nop();
    check({tag, "_vlow"}, 32'(DRAM_valid), 32'd0);
    check({tag, "_hold"}, DRAM_Q, exp);
  endtask

  initial begin
    logic seen;
    checks  = 0;
    errors  = 0;
    set_nop();
    ARESETn = 1'b0;
    @(posedge ACLK);
    #1;
    check("rst_q", DRAM_Q, 32'h0);
    check("rst_valid", 32'(DRAM_valid), 32'd0);
    check("rst_err", 32'(cmd_err), 32'd0);
    ARESETn = 1'b1;
    nops(2);

    // READ while IDLE: error pulse, no data.
    rd(11'h010);
    check("idle_rd_err", 32'(cmd_err), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < int'(CAS_LAT) + 2; i++) begin
      nop();
      if (DRAM_valid) seen = 1'b1;
      if (i == 0) check("idle_rd_err_1cyc", 32'(cmd_err), 32'd0);
    end
    check("idle_rd_novalid", 32'(seen), 32'd0);

    // ACT still legal => state stayed IDLE.
    act(11'h005);
    check("act_err", 32'(cmd_err), 32'd0);
    nops(5);
    wr(11'h010, 4'h0, 32'hDEADBEEF);
    check("wr_err", 32'(cmd_err), 32'd0);
    read_expect(11'h010, 32'hDEADBEEF, "basic");

    // ACT while ACTIVE: error, open row kept.
    act(11'h007);
    check("act_active_err", 32'(cmd_err), 32'd1);
    read_expect(11'h010, 32'hDEADBEEF, "row_kept");

    // Byte-masked write.
    wr(11'h020, 4'h0, 32'h11223344);
    wr(11'h020, 4'b1010, 32'hAABBCCDD);
    read_expect(11'h020, 32'h11BB33DD, "bytemask");

    // Back-to-back reads.
    wr(11'h001, 4'h0, 32'hA1A1A1A1);
    wr(11'h002, 4'h0, 32'hB2B2B2B2);
    wr(11'h003, 4'h0, 32'hC3C3C3C3);
    rd(11'h001);
    rd(11'h002);
    rd(11'h003);
    nop();
    check("b2b_v0", 32'(DRAM_valid), 32'd0);
    nop();
    check("b2b_v1", 32'(DRAM_valid), 32'd1);
    check("b2b_d1", DRAM_Q, 32'hA1A1A1A1);
    nop();
    check("b2b_v2", 32'(DRAM_valid), 32'd1);
    check("b2b_d2", DRAM_Q, 32'hB2B2B2B2);
    nop();
    check("b2b_v3", 32'(DRAM_valid), 32'd1);
    check("b2b_d3", DRAM_Q, 32'hC3C3C3C3);
    nop();
    check("b2b_vend", 32'(DRAM_valid), 32'd0);
    check("b2b_hold", DRAM_Q, 32'hC3C3C3C3);

    // PRE right behind a READ does not cancel it.
    rd(11'h020);
    pre();
    check("pre_err", 32'(cmd_err), 32'd0);
    nops(2);
    nop();
    check("pre_keep_valid", 32'(DRAM_valid), 32'd1);
    check("pre_keep_data", DRAM_Q, 32'h11BB33DD);

    // READ two cycles after ACT.
    nops(5);
    act(11'h005);
    check("act2_err", 32'(cmd_err), 32'd0);
    nop();
`ifdef DRAM_TIMING_CHECK_EN
    rd(11'h010);
    check("trcd_err", 32'(cmd_err), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < int'(CAS_LAT) + 2; i++) begin
      nop();
      if (DRAM_valid) seen = 1'b1;
    end
    check("trcd_novalid", 32'(seen), 32'd0);
`else
    read_expect(11'h010, 32'hDEADBEEF, "early_rd");
`endif

    // Reset in the middle of a read.
    nops(5);
    wr(11'h030, 4'h0, 32'hCAFEF00D);
    rd(11'h030);
    nops(2);
    ARESETn = 1'b0;
    #1;
    check("mid_rst_q", DRAM_Q, 32'h0);
    check("mid_rst_valid", 32'(DRAM_valid), 32'd0);
    nops(2);
    ARESETn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < int'(CAS_LAT) + 4; i++) begin
      nop();
      if (DRAM_valid) seen = 1'b1;
    end
    check("post_rst_novalid", 32'(seen), 32'd0);
    pre();
    check("post_rst_idle", 32'(cmd_err), 32'd1);
    act(11'h005);
    check("post_rst_act", 32'(cmd_err), 32'd0);
    nops(5);
    read_expect(11'h030, 32'hCAFEF00D, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
